seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Parametrised successor to the team's fixed 4-digit seven-segment multiplexer.
- Scans NUM_DIGITS digits, using a clock-enable prescaler rather than a derived clock.
- Adds tear-free double-buffered updates, hex/decimal decode, per-digit decimal points, leading-zero blanking, per-digit blink and 16-level PWM brightness.
- Sits between the parking-status logic and the board's common-anode display.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- DIV_BITS, 18: prescaler width; each digit slot lasts 2^DIV_BITS clocks (minimum 5).
- BLINK_FRAMES, 32: number of full frames per blink half-period.
- HEX_MODE, 0: 1 decodes 10-15 as A,b,C,d,E,F; 0 blanks them.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  BCD/hex values; digit i is bits [4i+3:4i]; i=0 is leftmost.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- blink_mask  in  NUM_DIGITS  1 = digit blinks.
- load  in  1  single-cycle strobe that captures digits, dp_in and blink_mask.
- lz_en  in  1  leading-zero blanking enable (quasi-static).
- brightness  in  4  0 = 1/16 duty, 15 = full duty (quasi-static).
- display_en  in  1  0 = all anodes off.
- seg_out  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1  decimal point, active-low.
- anode  out  NUM_DIGITS  one-hot active-low; bit i drives digit i.
- update_pending  out  1  a load is captured but not yet displayed.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset values (async, reset=0):
  - prescaler = 0, idx = 0, blink counter = 0, blink_phase = 0.
  - Active and pending buffers = 0; update_pending = 0.
  - Outputs: anode all 1s, seg_out 7'b1111111, dp_out 1, frame_start 0.
- Prescaler: free-running DIV_BITS counter. tick = (prescaler == all 1s).
- Scan index: on tick, idx <= (idx == NUM_DIGITS-1) ? 0 : idx+1.
  - Frame boundary = tick while idx == NUM_DIGITS-1.
  - frame_start is registered high on the cycle idx becomes 0.
- Double buffering:
  - load captures inputs into the pending buffer and sets update_pending. Several loads within one frame: the last one wins.
  - At a frame boundary with update_pending=1, active <= pending and update_pending clears.
  - load on the same cycle as a frame boundary: active <= the live inputs directly; update_pending ends at 0.
- Decode: values 0-9 use standard active-low codes (0 = 1000000, 8 = 0000000).
  - HEX_MODE=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - HEX_MODE=0: values 10-15 give 1111111.
- Leading-zero blanking: when lz_en=1, digit i is blanked if active digits 0..i are all 0 and i < NUM_DIGITS-1. The rightmost digit is never suppressed. The dp of a suppressed digit still shows.
- Blink:
  - The blink counter increments at each frame boundary.
  - At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - While blink_phase=1, digits with active blink_mask bit set show seg 1111111 and dp 1.
- Anode enable: anode[idx] = 0 only when all of the following hold:
  - display_en = 1;
  - prescaler[DIV_BITS-1 -: 4] <= brightness;
  - prescaler != 0 (one-cycle ghost guard at each slot start).
  - Otherwise all anode bits are 1.
- Latency: all outputs are registered. seg_out, dp_out and anode reflect idx, active buffer and prescaler state with exactly 1 clock lag. Segment and anode always change together, so there is no cross-digit glitch.
- display_en=0 forces anodes off but scanning, buffering and blink continue.
- Reset mid-frame discards pending data and restarts the scan at digit 0.

Test Plan:
- Load digits {1,2,3,4} (NUM_DIGITS=4, DIV_BITS=6) before the first frame ends -> each 64-cycle slot shows seg 1111001, 0100100, 0110000, 0011001 in turn; anode cycles 1110, 1101, 1011, 0111.
- load mid-frame while digit 1 is shown -> update_pending=1; segment content is unchanged until frame_start; new values appear in slot 0; update_pending falls at the boundary.
- Leading zeros: digits {0,0,0,0} with lz_en=1 -> digits 0-2 blank, digit 3 shows 1000000. Digits {0,0,7,0} -> digits 0-1 blank; 7 and 0 shown.
- Brightness sweep: brightness=0 -> anode low 3 of 64 slot cycles (ghost guard removes cycle 0). brightness=15 -> 63 of 64. display_en=0 -> anode stays 1111.
- Blink: BLINK_FRAMES=2, blink_mask=0100 -> digit 2 blank in alternate 2-frame windows; other digits are never blanked.
- Edge cases:
  - HEX_MODE=0, digit=4'hA -> 1111111.
  - HEX_MODE=1 -> 0001000.
  - load coinciding with a frame boundary -> new data shown in the next slot 0 with update_pending=0.
  - reset asserted mid-frame -> outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed common-anode seven-segment scanner with
// double-buffered loads, hex/BCD decode, leading-zero blanking, blink and PWM.
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   digits         4 bits per digit, digit i in [4i+3:4i], digit 0 leftmost
//   dp_in          decimal point per digit, 1 = lit
//   blink_mask     1 = digit blinks
//   load           strobe capturing digits, dp_in and blink_mask
//   lz_en          leading-zero blanking enable
//   brightness     0 = 1/16 duty .. 15 = full duty
//   display_en     0 forces all anodes off
//   seg_out        {g,f,e,d,c,b,a}, active-low
//   dp_out         decimal point, active-low
//   anode          one-hot active-low digit select
//   update_pending a load is captured but not yet displayed
//   frame_start    one-cycle pulse when the scan wraps to digit 0
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_BITS     = 18,
    parameter int BLINK_FRAMES = 32,
    parameter int HEX_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [3:0]              brightness,
    input  logic                    display_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    update_pending,
    output logic                    frame_start
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] LAST_BLINK = BW'(BLINK_FRAMES - 1);
    localparam bit HEX = (HEX_MODE != 0);

    logic [DIV_BITS-1:0]     prescaler;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp, pend_blink, act_blink;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    run, tick, frame_bnd, blink_off, blank, lit;
    logic [3:0]              cur;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = HEX ? 7'b0001000 : 7'b1111111;
            4'hB: decode = HEX ? 7'b0000011 : 7'b1111111;
            4'hC: decode = HEX ? 7'b1000110 : 7'b1111111;
            4'hD: decode = HEX ? 7'b0100001 : 7'b1111111;
            4'hE: decode = HEX ? 7'b0000110 : 7'b1111111;
            default: decode = HEX ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    // lz_mask[i] is set while digits 0..i are all zero; the rightmost digit is never masked
    always_comb begin
        lz_mask = '0;
        run = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            run = run & (act_digits[4*i +: 4] == 4'd0);
            lz_mask[i] = run;
        end
    end

    assign tick      = &prescaler;
    assign frame_bnd = tick && (idx == LAST_IDX);
    assign cur       = act_digits[{idx, 2'b00} +: 4];
    assign blink_off = blink_phase & act_blink[idx];
    assign blank     = blink_off | (lz_en & lz_mask[idx]);
    // prescaler == 0 keeps the anode dark for the first cycle of every slot
    assign lit       = display_en && (prescaler[DIV_BITS-1 -: 4] <= brightness) && (prescaler != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler      <= '0;
            idx            <= '0;
            blink_cnt      <= '0;
            blink_phase    <= 1'b0;
            pend_digits    <= '0;
            pend_dp        <= '0;
            pend_blink     <= '0;
            act_digits     <= '0;
            act_dp         <= '0;
            act_blink      <= '0;
            update_pending <= 1'b0;
            seg_out        <= 7'b1111111;
            dp_out         <= 1'b1;
            anode          <= '1;
            frame_start    <= 1'b0;
        end else begin
            prescaler   <= prescaler + DIV_BITS'(1);
            frame_start <= frame_bnd;
            if (tick)
                idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            if (load) begin
                pend_digits <= digits;
                pend_dp     <= dp_in;
                pend_blink  <= blink_mask;
            end
            // a load landing on the boundary bypasses the pending buffer
            if (frame_bnd && load) begin
                act_digits     <= digits;
                act_dp         <= dp_in;
                act_blink      <= blink_mask;
                update_pending <= 1'b0;
            end else if (frame_bnd && update_pending) begin
                act_digits     <= pend_digits;
                act_dp         <= pend_dp;
                act_blink      <= pend_blink;
                update_pending <= 1'b0;
            end else if (load) begin
                update_pending <= 1'b1;
            end
            if (frame_bnd) begin
                blink_cnt <= (blink_cnt == LAST_BLINK) ? '0 : blink_cnt + BW'(1);
                if (blink_cnt == LAST_BLINK)
                    blink_phase <= ~blink_phase;
            end
            seg_out <= blank ? 7'b1111111 : decode(cur);
            dp_out  <= ~(act_dp[idx] & ~blink_off);
            anode   <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench for seven_seg_scan_driver (4 digits, 64-cycle slots).
module tb_seven_seg_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic        display_en = 1'b1;
    logic [6:0]  seg_out, seg_h;
    logic        dp_out, dp_h;
    logic [3:0]  anode, anode_h;
    logic        update_pending, up_h, frame_start, fs_h;

    int checks = 0;
    int failures = 0;
    logic [11:0] sb[$];
    logic [6:0]  sbh[$];
    int          cq[$];
    logic [11:0] obs[4];
    logic [6:0]  obs_h[4];
    logic        obs_up;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .DIV_BITS(6), .BLINK_FRAMES(2), .HEX_MODE(0)) dut (
        .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .blink_mask(blink_mask),
        .load(load), .lz_en(lz_en), .brightness(brightness), .display_en(display_en),
        .seg_out(seg_out), .dp_out(dp_out), .anode(anode),
        .update_pending(update_pending), .frame_start(frame_start)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .DIV_BITS(6), .BLINK_FRAMES(2), .HEX_MODE(1)) dut_hex (
        .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .blink_mask(blink_mask),
        .load(load), .lz_en(lz_en), .brightness(brightness), .display_en(display_en),
        .seg_out(seg_h), .dp_out(dp_h), .anode(anode_h),
        .update_pending(up_h), .frame_start(fs_h)
    );

    function automatic logic [6:0] code(input logic [3:0] v, input bit hex);
        case (v)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = hex ? 7'b0001000 : 7'b1111111;
            4'hB: code = hex ? 7'b0000011 : 7'b1111111;
            4'hC: code = hex ? 7'b1000110 : 7'b1111111;
            4'hD: code = hex ? 7'b0100001 : 7'b1111111;
            4'hE: code = hex ? 7'b0000110 : 7'b1111111;
            default: code = hex ? 7'b0001110 : 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] slot_exp(input logic [6:0] seg, input bit dp_lit, input int s);
        logic [3:0] an;
        an = ~(4'b0001 << s);
        return {seg, ~dp_lit, an};
    endfunction

    task automatic wait_frame();
        int t = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (frame_start !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_frame: frame_start=%b required 1 within 1000 cycles", frame_start);
        end
    endtask

    // after frame_start, capture each slot 33 cycles in (state prescaler=32)
    task automatic sample_slots();
        for (int s = 0; s < 4; s++) begin
            repeat (s == 0 ? 33 : 64) @(negedge clk);
            obs[s] = {seg_out, dp_out, anode};
            obs_h[s] = seg_h;
        end
    endtask

    task automatic sample_frame();
        wait_frame();
        obs_up = update_pending;
        sample_slots();
    endtask

    task automatic pulse_load();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 5;
        if (anode !== 4'hF) begin failures++; $display("FAIL reset anode: got %b required 1111", anode); end
        if (seg_out !== 7'h7F) begin failures++; $display("FAIL reset seg: got %b required 1111111", seg_out); end
        if (dp_out !== 1'b1) begin failures++; $display("FAIL reset dp: got %b required 1", dp_out); end
        if (frame_start !== 1'b0) begin failures++; $display("FAIL reset frame_start: got %b required 0", frame_start); end
        if (update_pending !== 1'b0) begin failures++; $display("FAIL reset pending: got %b required 0", update_pending); end
        reset = 1'b1;
    endtask

    task automatic test_scan();
        logic [11:0] e;
        digits = 16'h4321;
        dp_in = 4'b0010;
        pulse_load();
        checks++;
        if (update_pending !== 1'b1) begin failures++; $display("FAIL scan pending after load: got %b required 1", update_pending); end
        for (int s = 0; s < 4; s++) sb.push_back(slot_exp(code(4'(s + 1), 0), s == 1, s));
        sample_frame();
        checks++;
        if (obs_up !== 1'b0) begin failures++; $display("FAIL scan pending at frame_start: got %b required 0", obs_up); end
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL scan slot%0d seg/dp/anode: got %b required %b", s, obs[s], e); end
        end
    endtask

    task automatic test_midframe_load();
        logic [11:0] e;
        wait_frame();
        repeat (74) @(negedge clk);
        digits = 16'h8765;
        dp_in = 4'b0000;
        pulse_load();
        checks++;
        if (update_pending !== 1'b1) begin failures++; $display("FAIL midframe pending: got %b required 1", update_pending); end
        sb.push_back(slot_exp(code(4'h3, 0), 0, 2));
        sb.push_back(slot_exp(code(4'h4, 0), 0, 3));
        repeat (86) @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({seg_out, dp_out, anode} !== e) begin failures++; $display("FAIL midframe old slot2: got %b required %b", {seg_out, dp_out, anode}, e); end
        repeat (64) @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({seg_out, dp_out, anode} !== e) begin failures++; $display("FAIL midframe old slot3: got %b required %b", {seg_out, dp_out, anode}, e); end
        repeat (30) @(negedge clk);
        checks++;
        if (update_pending !== 1'b1) begin failures++; $display("FAIL midframe pending before boundary: got %b required 1", update_pending); end
        for (int s = 0; s < 4; s++) sb.push_back(slot_exp(code(4'(s + 5), 0), 0, s));
        sample_frame();
        checks++;
        if (obs_up !== 1'b0) begin failures++; $display("FAIL midframe pending after boundary: got %b required 0", obs_up); end
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL midframe new slot%0d: got %b required %b", s, obs[s], e); end
        end
    endtask

    task automatic test_leading_zero();
        logic [11:0] e;
        lz_en = 1'b1;
        digits = 16'h0000;
        dp_in = 4'b0001;
        pulse_load();
        sb.push_back(slot_exp(7'h7F, 1, 0));
        sb.push_back(slot_exp(7'h7F, 0, 1));
        sb.push_back(slot_exp(7'h7F, 0, 2));
        sb.push_back(slot_exp(code(4'h0, 0), 0, 3));
        sample_frame();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL lz all-zero slot%0d: got %b required %b", s, obs[s], e); end
        end
        digits = 16'h0700;
        dp_in = 4'b0000;
        pulse_load();
        sb.push_back(slot_exp(7'h7F, 0, 0));
        sb.push_back(slot_exp(7'h7F, 0, 1));
        sb.push_back(slot_exp(code(4'h7, 0), 0, 2));
        sb.push_back(slot_exp(code(4'h0, 0), 0, 3));
        sample_frame();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL lz 0070 slot%0d: got %b required %b", s, obs[s], e); end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_brightness();
        logic [3:0] br[4] = '{4'd0, 4'd7, 4'd15, 4'd15};
        int exp_cnt[4] = '{12, 124, 252, 0};
        int cnt, e;
        for (int i = 0; i < 4; i++) begin
            brightness = br[i];
            display_en = (i != 3);
            cq.push_back(exp_cnt[i]);
            wait_frame();
            cnt = 0;
            repeat (256) begin
                @(negedge clk);
                if (anode !== 4'hF) cnt++;
            end
            e = cq.pop_front();
            checks++;
            if (cnt !== e) begin failures++; $display("FAIL brightness %0d en=%b lit cycles: got %0d required %0d", br[i], display_en, cnt, e); end
        end
        brightness = 4'hF;
        display_en = 1'b1;
    endtask

    task automatic test_hex();
        logic [11:0] e;
        logic [6:0] eh;
        digits = 16'hF0BA;
        dp_in = 4'b0000;
        pulse_load();
        sb.push_back(slot_exp(7'h7F, 0, 0));
        sb.push_back(slot_exp(7'h7F, 0, 1));
        sb.push_back(slot_exp(code(4'h0, 0), 0, 2));
        sb.push_back(slot_exp(7'h7F, 0, 3));
        sbh.push_back(7'b0001000);
        sbh.push_back(7'b0000011);
        sbh.push_back(7'b1000000);
        sbh.push_back(7'b0001110);
        sample_frame();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            eh = sbh.pop_front();
            checks += 2;
            if (obs[s] !== e) begin failures++; $display("FAIL hex off slot%0d: got %b required %b", s, obs[s], e); end
            if (obs_h[s] !== eh) begin failures++; $display("FAIL hex on slot%0d seg: got %b required %b", s, obs_h[s], eh); end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        wait_frame();
        repeat (255) @(negedge clk);
        checks++;
        if (update_pending !== 1'b0) begin failures++; $display("FAIL b2b pending before: got %b required 0", update_pending); end
        digits = 16'h5698;
        dp_in = 4'b1000;
        pulse_load();
        checks += 2;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL b2b frame_start: got %b required 1", frame_start); end
        if (update_pending !== 1'b0) begin failures++; $display("FAIL b2b pending after boundary load: got %b required 0", update_pending); end
        sb.push_back(slot_exp(code(4'h8, 0), 0, 0));
        sb.push_back(slot_exp(code(4'h9, 0), 0, 1));
        sb.push_back(slot_exp(code(4'h6, 0), 0, 2));
        sb.push_back(slot_exp(code(4'h5, 0), 1, 3));
        sample_slots();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL b2b boundary slot%0d: got %b required %b", s, obs[s], e); end
        end
        digits = 16'h1111;
        dp_in = 4'b0000;
        pulse_load();
        digits = 16'h2222;
        pulse_load();
        for (int s = 0; s < 4; s++) sb.push_back(slot_exp(code(4'h2, 0), 0, s));
        sample_frame();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL b2b last-load slot%0d: got %b required %b", s, obs[s], e); end
        end
    endtask

    task automatic test_blink();
        logic [11:0] e;
        bit on;
        do_reset();
        blink_mask = 4'b0100;
        dp_in = 4'b0100;
        digits = 16'h4321;
        pulse_load();
        for (int k = 1; k <= 6; k++) begin
            on = ((k / 2) % 2) == 1;
            for (int s = 0; s < 4; s++)
                sb.push_back((s == 2 && on) ? slot_exp(7'h7F, 0, s) : slot_exp(code(4'(s + 1), 0), s == 2, s));
            sample_frame();
            for (int s = 0; s < 4; s++) begin
                e = sb.pop_front();
                checks++;
                if (obs[s] !== e) begin failures++; $display("FAIL blink frame%0d slot%0d: got %b required %b", k, s, obs[s], e); end
            end
        end
        blink_mask = 4'b0000;
        dp_in = 4'b0000;
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        int t;
        wait_frame();
        repeat (40) @(negedge clk);
        digits = 16'h9999;
        pulse_load();
        checks += 2;
        if (update_pending !== 1'b1) begin failures++; $display("FAIL areset pending before: got %b required 1", update_pending); end
        if (anode !== 4'b1110) begin failures++; $display("FAIL areset anode before: got %b required 1110", anode); end
        #2 reset = 1'b0;
        #1;
        checks += 5;
        if (anode !== 4'hF) begin failures++; $display("FAIL areset anode: got %b required 1111", anode); end
        if (seg_out !== 7'h7F) begin failures++; $display("FAIL areset seg: got %b required 1111111", seg_out); end
        if (dp_out !== 1'b1) begin failures++; $display("FAIL areset dp: got %b required 1", dp_out); end
        if (update_pending !== 1'b0) begin failures++; $display("FAIL areset pending: got %b required 0", update_pending); end
        if (frame_start !== 1'b0) begin failures++; $display("FAIL areset frame_start: got %b required 0", frame_start); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (frame_start !== 1'b1 && t < 600);
        checks += 2;
        if (t !== 256) begin failures++; $display("FAIL areset first frame_start cycle: got %0d required 256", t); end
        if (update_pending !== 1'b0) begin failures++; $display("FAIL areset pending after restart: got %b required 0", update_pending); end
        for (int s = 0; s < 4; s++) sb.push_back(slot_exp(code(4'h0, 0), 0, s));
        sample_slots();
        for (int s = 0; s < 4; s++) begin
            e = sb.pop_front();
            checks++;
            if (obs[s] !== e) begin failures++; $display("FAIL areset cleared slot%0d: got %b required %b", s, obs[s], e); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_leading_zero();
        test_brightness();
        test_hex();
        test_back_to_back();
        test_blink();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
